// File: rtl/dsm_mod.sv
// First-order delta-sigma modulator with a one-entry valid/ready sample buffer.
// Define DSM_DITHER_EN to add a 16-bit LFSR dither bit into the accumulator sum.
module dsm_mod #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned OSR       = 32,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              dout,
    output logic              sample_tick,
    output logic              underrun
);

    localparam int unsigned CNT_W = $clog2(OSR);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OSR - 1);

    if (LFSR_SEED == 16'h0000 || OSR < 2) begin : g_bad_param
        $error("dsm_mod: LFSR_SEED must be nonzero and OSR at least 2");
    end

    logic [DATA_W-1:0] buf_data;
    logic              buf_full;
    logic [DATA_W-1:0] cur;
    logic [DATA_W-1:0] acc;
    logic [CNT_W-1:0]  cnt;
    logic              boundary;
    logic              wr;
    logic              dither;
    logic [DATA_W:0]   sum;

    assign s_ready  = !buf_full;
    assign wr       = s_valid && !buf_full;
    assign boundary = en && (cnt == CNT_MAX);

`ifdef DSM_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (en) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign dither = lfsr[0];
`else
    assign dither = 1'b0;
`endif

    always_comb begin
        sum = {1'b0, acc} + {1'b0, cur} + {{DATA_W{1'b0}}, dither};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_data    <= '0;
            buf_full    <= 1'b0;
            cur         <= '0;
            acc         <= '0;
            cnt         <= '0;
            dout        <= 1'b0;
            sample_tick <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            sample_tick <= boundary;
            underrun    <= boundary && !buf_full;
            if (wr) begin
                buf_data <= s_data;
            end
            // a write on a boundary with an empty buffer is held for the next boundary
            if (boundary && buf_full) begin
                cur      <= buf_data;
                buf_full <= 1'b0;
            end else if (wr) begin
                buf_full <= 1'b1;
            end
            if (en) begin
                cnt  <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
                acc  <= sum[DATA_W-1:0];
                dout <= sum[DATA_W];
            end else begin
                dout <= 1'b0;
            end
        end
    end

endmodule
